// File: rtl/game_round_controller.sv
// Round sequencer for the LED reaction game: IDLE -> READY countdown -> PLAY window -> OVER.
// Owns the ms prescaler and seconds countdown, and keeps the final and high scores.
`timescale 1ns/1ps
module game_round_controller #(
    parameter int CLKS_PER_MS   = 50000,
    parameter int GAME_SECONDS  = 30,
    parameter int READY_SECONDS = 3,
    parameter int SCORE_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_button,
    input  logic [SCORE_W-1:0]  player_score,
    output logic                game_reset,
    output logic                game_enable,
    output logic                ms_tick,
    output logic [$clog2((GAME_SECONDS > READY_SECONDS ? GAME_SECONDS : READY_SECONDS) + 1)-1:0] seconds_left,
    output logic [1:0]          phase,
    output logic [SCORE_W-1:0]  final_score,
    output logic [SCORE_W-1:0]  high_score,
    output logic                new_high
);

    localparam int MAX_SEC = (GAME_SECONDS > READY_SECONDS) ? GAME_SECONDS : READY_SECONDS;
    localparam int SEC_W   = $clog2(MAX_SEC + 1);
    localparam int PRESC_W = $clog2(CLKS_PER_MS);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_MS - 1);
    localparam logic [9:0]         MS_LAST    = 10'd999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             state_reg;
    logic [PRESC_W-1:0] presc_reg;
    logic [9:0]         ms_cnt_reg;
    logic               btn_reg;
    logic               armed_reg;
    logic [SEC_W-1:0]   seconds_reg;
    logic [SCORE_W-1:0] final_score_reg;
    logic [SCORE_W-1:0] high_score_reg;
    logic               new_high_reg;

    logic running;
    logic tick_now;
    logic sec_boundary;
    logic btn_edge;

    assign running      = (state_reg == S_READY) || (state_reg == S_PLAY);
    assign tick_now     = running && (presc_reg == PRESC_LAST);
    assign sec_boundary = tick_now && (ms_cnt_reg == MS_LAST);
    // armed_reg masks the level seen on the first clock after reset release.
    assign btn_edge     = armed_reg && start_button && !btn_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            presc_reg       <= '0;
            ms_cnt_reg      <= '0;
            btn_reg         <= 1'b0;
            armed_reg       <= 1'b0;
            seconds_reg     <= SEC_W'(GAME_SECONDS);
            final_score_reg <= '0;
            high_score_reg  <= '0;
            new_high_reg    <= 1'b0;
        end else begin
            btn_reg   <= start_button;
            armed_reg <= 1'b1;

            if (running) begin
                presc_reg <= tick_now ? '0 : presc_reg + PRESC_W'(1);
                if (tick_now)
                    ms_cnt_reg <= (ms_cnt_reg == MS_LAST) ? '0 : ms_cnt_reg + 10'd1;
            end else begin
                presc_reg  <= '0;
                ms_cnt_reg <= '0;
            end

            case (state_reg)
                S_IDLE: begin
                    seconds_reg <= SEC_W'(GAME_SECONDS);
                    if (btn_edge) begin
                        state_reg   <= S_READY;
                        seconds_reg <= SEC_W'(READY_SECONDS);
                        presc_reg   <= '0;
                        ms_cnt_reg  <= '0;
                    end
                end
                S_READY: begin
                    if (sec_boundary) begin
                        if (seconds_reg == SEC_W'(1)) begin
                            state_reg   <= S_PLAY;
                            seconds_reg <= SEC_W'(GAME_SECONDS);
                            presc_reg   <= '0;
                            ms_cnt_reg  <= '0;
                        end else begin
                            seconds_reg <= seconds_reg - SEC_W'(1);
                        end
                    end
                end
                S_PLAY: begin
                    if (sec_boundary) begin
                        if (seconds_reg == SEC_W'(1)) begin
                            state_reg       <= S_OVER;
                            seconds_reg     <= '0;
                            presc_reg       <= '0;
                            ms_cnt_reg      <= '0;
                            final_score_reg <= player_score;
                            // A tie with the standing high score is not a new record.
                            if (player_score > high_score_reg) begin
                                high_score_reg <= player_score;
                                new_high_reg   <= 1'b1;
                            end else begin
                                new_high_reg   <= 1'b0;
                            end
                        end else begin
                            seconds_reg <= seconds_reg - SEC_W'(1);
                        end
                    end
                end
                S_OVER: begin
                    seconds_reg <= '0;
                    if (btn_edge) begin
                        state_reg    <= S_READY;
                        seconds_reg  <= SEC_W'(READY_SECONDS);
                        new_high_reg <= 1'b0;
                        presc_reg    <= '0;
                        ms_cnt_reg   <= '0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign phase        = state_reg;
    assign game_reset   = (state_reg != S_PLAY);
    assign game_enable  = (state_reg == S_PLAY);
    assign ms_tick      = tick_now;
    assign seconds_left = seconds_reg;
    assign final_score  = final_score_reg;
    assign high_score   = high_score_reg;
    assign new_high     = new_high_reg;

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Sequences one timed game of the LED reaction game: idle, get-ready countdown, timed play window, game over.
- Owns the millisecond prescaler and the seconds countdown.
- Holds the reaction FSM in reset or releases it through game_reset and game_enable.
- At game end, latches the player's score and maintains the session high score for the display logic.

Parameters:
- CLKS_PER_MS, 50000: clk cycles per millisecond tick (50 MHz clk). Must be at least 2.
- GAME_SECONDS, 30: length of the play window, in seconds. Must be at least 1.
- READY_SECONDS, 3: length of the get-ready countdown, in seconds. Must be at least 1.
- SCORE_W, 4: width of the player score and high score.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_button  in  1  debounced, synchronised button level.
- player_score  in  SCORE_W  running score from the reaction FSM.
- game_reset  out  1  high holds the reaction FSM and its timers in reset.
- game_enable  out  1  high lets the reaction FSM run.
- ms_tick  out  1  one-cycle pulse per elapsed millisecond while a countdown runs.
- seconds_left  out  $clog2(max(GAME_SECONDS,READY_SECONDS)+1)  value for the seconds display.
- phase  out  2  current state: 0=IDLE, 1=READY, 2=PLAY, 3=OVER.
- final_score  out  SCORE_W  player_score latched at the end of the game.
- high_score  out  SCORE_W  best final_score since reset.
- new_high  out  1  high throughout OVER if this game set a new high score.

Behaviour:
- Reset (rst_n low, async, any state) forces:
  - phase=IDLE, game_reset=1, game_enable=0, ms_tick=0
  - seconds_left=GAME_SECONDS
  - final_score=0, high_score=0, new_high=0
  - prescaler, ms counter and button edge register cleared.
- Button edge: start_button rises (registered copy low, input high). One-cycle event. The start_button level sampled on the first clk after reset release cannot produce an edge.
- Prescaler:
  - Counts 0..CLKS_PER_MS-1 in READY and PLAY only.
  - ms_tick=1 in the cycle the count equals CLKS_PER_MS-1, then the count wraps to 0.
  - The ms counter counts ms_ticks 0..999.
  - sec_boundary = ms_tick with ms counter at 999; the ms counter then wraps to 0.
  - Both counters clear on every state entry, so the first boundary comes exactly 1000*CLKS_PER_MS cycles after entry.
- IDLE:
  - game_reset=1, game_enable=0, seconds_left=GAME_SECONDS.
  - Button edge -> READY, with seconds_left loaded to READY_SECONDS.
- READY:
  - game_reset=1, game_enable=0.
  - Each sec_boundary decrements seconds_left.
  - sec_boundary with seconds_left==1 -> PLAY, with seconds_left loaded to GAME_SECONDS.
  - Button edges are ignored.
- PLAY:
  - game_reset=0, game_enable=1.
  - Each sec_boundary decrements seconds_left.
  - sec_boundary with seconds_left==1 -> OVER, with seconds_left=0. On that same edge:
    - final_score <= player_score
    - if player_score > high_score (strictly greater): high_score <= player_score and new_high <= 1
    - otherwise new_high <= 0.
  - Button edges are ignored, including one in the same cycle as the final boundary.
- OVER:
  - game_reset=1, game_enable=0, seconds_left=0.
  - final_score, high_score and new_high hold.
  - Button edge -> READY; new_high clears on that transition and final_score holds.
- All outputs are registered or decoded directly from registered state. There is no combinational path from any input to any output.
- A score equal to high_score does not set new_high.
- high_score is never reset except by rst_n.

Test Plan:
- Sim parameters for all scenarios: CLKS_PER_MS=2, READY_SECONDS=2, GAME_SECONDS=3. One second = 2000 clk cycles.
- Reset then idle 100 cycles:
  - phase=0, game_reset=1, game_enable=0, seconds_left=3, high_score=0, ms_tick never pulses.
- Button press in IDLE:
  - Next cycle: phase=1, seconds_left=2.
  - After 2000 cycles: seconds_left=1.
  - After 4000 cycles: phase=2, seconds_left=3, game_reset=0, game_enable=1.
  - ms_tick pulses every 2nd cycle throughout.
- Full game with player_score=5:
  - 6000 cycles after PLAY entry: phase=3, seconds_left=0, final_score=5, high_score=5, new_high=1.
  - Button press: phase=1, new_high=0.
- Second game with player_score=5, then third game with player_score=7:
  - Second game ends with high_score=5, new_high=0 (equal score does not count).
  - Third game ends with high_score=7, new_high=1.
- Button edges during READY, during PLAY and on the final PLAY boundary cycle:
  - No phase change; the game ends at the normal time.
- rst_n low for 1 cycle mid-PLAY after a game that left high_score=7:
  - phase=0, game_reset=1, high_score=0, seconds_left=3, all applied asynchronously before the next clk edge.
